// File: rtl/duck_pkg.sv
// Shared types and constants for the duck motion controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package duck_pkg;

  // Round phases of the duck motion controller
  typedef enum logic [2:0] {
    IDLE,
    FLY,
    HIT_PAUSE,
    FALL,
    ESCAPE,
    DONE
  } duck_state_t;

  // Per-axis flight step in accumulator LSBs per cycle, indexed by speed_lvl
  localparam logic [3:0][8:0] SPEED_TBL = {9'd160, 9'd128, 9'd96, 9'd64};

  // Downward step per cycle while the shot duck drops to the grass
  localparam logic [8:0] FALL_STEP = 9'd120;

  // Power-on value of the direction-choice LFSR
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/duck_lfsr16.sv
// 16-bit Galois LFSR (taps 16/14/13/11), free running from LFSR_SEED.
// Latency: new value every cycle. Backpressure: none, never stalls.
// Ports: clk, rst_n (async active-low, loads seed), q[15:0] current state.
module lfsr16
  import duck_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // Right-shifting Galois form: the bit shifted out is folded back into the tap positions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/duck_move_ctl.sv
// Duck sprite motion: fixed-point flight with edge bounces, hit pause + fall, timeout escape.
// Latency: xpos/ypos show each step one cycle after it; dog_enable is a 1-cycle pulse in DONE.
// Backpressure: none; start only sampled in IDLE, hit only in FLY.
// Ports: clk, rst_n (async active-low); start, hit, speed_lvl[1:0] in;
//        xpos/ypos[11:0], duck_visible, falling, dog_enable, round_hit out.
// Optional: define DUCK_RANDOM_TURN_EN for pseudo-random direction flips during FLY.
module duck_move_ctl
  import duck_pkg::*;
#(
  parameter int unsigned FRAC_BITS        = 24,
  parameter int unsigned X_MIN            = 0,
  parameter int unsigned X_MAX            = 960,
  parameter int unsigned Y_MIN            = 32,
  parameter int unsigned Y_MAX            = 448,
  parameter int unsigned GROUND_Y         = 480,
  parameter int unsigned ESCAPE_Y         = 8,
  parameter int unsigned START_X          = 480,
  parameter int unsigned START_Y          = 448,
  parameter int unsigned HIT_PAUSE_CYCLES = 32500000,
  parameter int unsigned FLY_TIMEOUT      = 325000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hit,
  input  logic [1:0]  speed_lvl,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        duck_visible,
  output logic        falling,
  output logic        dog_enable,
  output logic        round_hit
);

  localparam int unsigned AW      = 12 + FRAC_BITS;
  localparam int unsigned CNT_MAX = (FLY_TIMEOUT > HIT_PAUSE_CYCLES) ? FLY_TIMEOUT : HIT_PAUSE_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [AW-1:0] acc_t;

  // Bounds in accumulator units. *_LIM values are the first accumulator value past the bound,
  // so "integer part > bound" becomes a single full-width compare.
  localparam acc_t X_LO      = acc_t'(X_MIN) << FRAC_BITS;
  localparam acc_t X_HI      = acc_t'(X_MAX) << FRAC_BITS;
  localparam acc_t X_HI_LIM  = acc_t'(X_MAX + 1) << FRAC_BITS;
  localparam acc_t Y_LO      = acc_t'(Y_MIN) << FRAC_BITS;
  localparam acc_t Y_HI      = acc_t'(Y_MAX) << FRAC_BITS;
  localparam acc_t Y_HI_LIM  = acc_t'(Y_MAX + 1) << FRAC_BITS;
  localparam acc_t GROUND_A  = acc_t'(GROUND_Y) << FRAC_BITS;
  localparam acc_t ESC_A     = acc_t'(ESCAPE_Y) << FRAC_BITS;
  localparam acc_t ESC_LIM   = acc_t'(ESCAPE_Y + 1) << FRAC_BITS;
  localparam acc_t X_SPAWN   = acc_t'(START_X) << FRAC_BITS;
  localparam acc_t Y_SPAWN   = acc_t'(START_Y) << FRAC_BITS;

  duck_state_t state, state_nxt;
  acc_t        x_acc, x_nxt, y_acc, y_nxt;
  logic        x_pos_dir, dxp_nxt;  // 1 = moving toward larger x
  logic        y_up, yup_nxt;       // 1 = moving toward smaller y (up the screen)
  logic [CW-1:0] cnt, cnt_nxt;
  logic [8:0]  spd, spd_nxt;
  logic        rh_nxt;
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Flight arithmetic; decreasing moves are compared before subtracting so nothing wraps
  acc_t step, esc_step, x_fly, y_fly, y_fall, y_esc;
  logic x_bounce, y_bounce, fall_end, esc_end, x_dir_fly, y_dir_fly;

  always_comb begin
    step     = acc_t'(spd);
    esc_step = acc_t'({spd, 1'b0});

    x_fly    = x_pos_dir ? x_acc + step : x_acc - step;
    x_bounce = 1'b0;
    if (x_pos_dir && (x_acc + step >= X_HI_LIM)) begin
      x_fly    = X_HI;
      x_bounce = 1'b1;
    end else if (!x_pos_dir && (x_acc < X_LO + step)) begin
      x_fly    = X_LO;
      x_bounce = 1'b1;
    end

    y_fly    = y_up ? y_acc - step : y_acc + step;
    y_bounce = 1'b0;
    if (y_up && (y_acc < Y_LO + step)) begin
      y_fly    = Y_LO;
      y_bounce = 1'b1;
    end else if (!y_up && (y_acc + step >= Y_HI_LIM)) begin
      y_fly    = Y_HI;
      y_bounce = 1'b1;
    end

    y_fall   = y_acc + acc_t'(FALL_STEP);
    fall_end = (y_fall >= GROUND_A);
    y_esc    = y_acc - esc_step;
    esc_end  = (y_acc < ESC_LIM + esc_step);
  end

`ifdef DUCK_RANDOM_TURN_EN
  logic [15:0] turn_cnt, turn_nxt;
  logic        turn_wrap;
  logic        lfsr_unused;
  assign lfsr_unused = ^lfsr_q[15:2];
  assign turn_wrap   = (turn_cnt == 16'hFFFF);
  // A bounce on an axis takes priority over the random flip of that axis
  assign x_dir_fly   = x_bounce ? ~x_pos_dir : (x_pos_dir ^ (turn_wrap & lfsr_q[0]));
  assign y_dir_fly   = y_bounce ? ~y_up      : (y_up      ^ (turn_wrap & lfsr_q[1]));
`else
  logic lfsr_unused;
  assign lfsr_unused = ^lfsr_q[15:1];
  assign x_dir_fly   = x_bounce ? ~x_pos_dir : x_pos_dir;
  assign y_dir_fly   = y_bounce ? ~y_up      : y_up;
`endif

  always_comb begin
    state_nxt    = state;
    x_nxt        = x_acc;
    y_nxt        = y_acc;
    dxp_nxt      = x_pos_dir;
    yup_nxt      = y_up;
    cnt_nxt      = cnt;
    spd_nxt      = spd;
    rh_nxt       = round_hit;
    duck_visible = 1'b0;
    falling      = 1'b0;
    dog_enable   = 1'b0;
`ifdef DUCK_RANDOM_TURN_EN
    turn_nxt     = turn_cnt;
`endif
    case (state)
      IDLE: begin
        x_nxt = X_SPAWN;
        y_nxt = Y_SPAWN;
        if (start) begin
          spd_nxt   = SPEED_TBL[speed_lvl];
          yup_nxt   = 1'b1;
          dxp_nxt   = lfsr_q[0];
          cnt_nxt   = '0;
          rh_nxt    = 1'b0;
          state_nxt = FLY;
`ifdef DUCK_RANDOM_TURN_EN
          turn_nxt  = '0;
`endif
        end
      end
      FLY: begin
        duck_visible = 1'b1;
        x_nxt        = x_fly;
        y_nxt        = y_fly;
        dxp_nxt      = x_dir_fly;
        yup_nxt      = y_dir_fly;
        cnt_nxt      = cnt + 1'b1;
`ifdef DUCK_RANDOM_TURN_EN
        turn_nxt     = turn_cnt + 16'd1;
`endif
        // hit outranks a timeout landing on the same cycle
        if (hit) begin
          rh_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = HIT_PAUSE;
        end else if (cnt == CW'(FLY_TIMEOUT - 1)) begin
          state_nxt = ESCAPE;
        end
      end
      HIT_PAUSE: begin
        duck_visible = 1'b1;
        falling      = 1'b1;
        if (cnt == CW'(HIT_PAUSE_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = FALL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FALL: begin
        duck_visible = 1'b1;
        falling      = 1'b1;
        if (fall_end) begin
          y_nxt     = GROUND_A;
          state_nxt = DONE;
        end else begin
          y_nxt = y_fall;
        end
      end
      ESCAPE: begin
        duck_visible = 1'b1;
        if (esc_end) begin
          y_nxt     = ESC_A;
          state_nxt = DONE;
        end else begin
          y_nxt = y_esc;
        end
      end
      DONE: begin
        dog_enable = 1'b1;
        x_nxt      = X_SPAWN;
        y_nxt      = Y_SPAWN;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_acc     <= X_SPAWN;
      y_acc     <= Y_SPAWN;
      x_pos_dir <= 1'b1;
      y_up      <= 1'b1;
      cnt       <= '0;
      spd       <= SPEED_TBL[0];
      round_hit <= 1'b0;
`ifdef DUCK_RANDOM_TURN_EN
      turn_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      x_acc     <= x_nxt;
      y_acc     <= y_nxt;
      x_pos_dir <= dxp_nxt;
      y_up      <= yup_nxt;
      cnt       <= cnt_nxt;
      spd       <= spd_nxt;
      round_hit <= rh_nxt;
`ifdef DUCK_RANDOM_TURN_EN
      turn_cnt  <= turn_nxt;
`endif
    end
  end

  assign xpos = x_acc[AW-1:FRAC_BITS];
  assign ypos = y_acc[AW-1:FRAC_BITS];

endmodule

// File: tb/tb_duck_move_ctl.sv
// Bench for duck_move_ctl: two instances (spawn x 480 and 950) checked every cycle
// against a pixel-arithmetic model, plus hand-computed checkpoints per scenario.
module tb_duck_move_ctl;

  localparam int FB  = 8;
  localparam int ONE = 1 << FB;
  localparam int TO  = 400;
  localparam int HP  = 10;
  localparam int P_IDLE = 0, P_FLY = 1, P_PAUSE = 2, P_FALL = 3, P_ESC = 4, P_DONE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, hit = 1'b0, start_b = 1'b0, hit_b = 1'b0;
  logic [1:0] sl = 2'd0, sl_b = 2'd3;
  logic [11:0] xpos, ypos, xpos_b, ypos_b;
  logic vis, fall, dog, rh, vis_b, fall_b, dog_b, rh_b;

  always #5 clk = ~clk;

  duck_move_ctl #(.FRAC_BITS(FB), .FLY_TIMEOUT(TO), .HIT_PAUSE_CYCLES(HP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .speed_lvl(sl),
    .xpos(xpos), .ypos(ypos), .duck_visible(vis), .falling(fall),
    .dog_enable(dog), .round_hit(rh));

  duck_move_ctl #(.FRAC_BITS(FB), .FLY_TIMEOUT(TO), .HIT_PAUSE_CYCLES(HP), .START_X(950)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hit(hit_b), .speed_lvl(sl_b),
    .xpos(xpos_b), .ypos(ypos_b), .duck_visible(vis_b), .falling(fall_b),
    .dog_enable(dog_b), .round_hit(rh_b));

  // ---------------- model (positions in 1/256 px) ----------------
  typedef struct packed {
    int ph; int x; int y; bit east; bit up; int n; int spd; bit rh;
  } mdl_t;

  mdl_t m0, m1;
  logic [15:0] lf;

  function automatic mdl_t reset_m(input int sx);
    mdl_t r;
    r.ph = P_IDLE; r.x = sx * ONE; r.y = 448 * ONE; r.east = 1'b1; r.up = 1'b1;
    r.n = 0; r.spd = 64; r.rh = 1'b0;
    return r;
  endfunction

  function automatic mdl_t step_m(input mdl_t c, input bit st, input bit ht,
                                  input logic [1:0] lvl, input bit coin, input int sx);
    mdl_t r;
    int nx, ny;
    r = c;
    case (c.ph)
      P_IDLE: if (st) begin
        r.ph = P_FLY; r.spd = 64 + 32 * int'(lvl); r.up = 1'b1; r.east = coin;
        r.n = 0; r.rh = 1'b0;
      end
      P_FLY: begin
        nx = c.east ? c.x + c.spd : c.x - c.spd;
        if (c.east && nx / ONE > 960) begin nx = 960 * ONE; r.east = 1'b0; end
        if (!c.east && nx < 0)        begin nx = 0;         r.east = 1'b1; end
        ny = c.up ? c.y - c.spd : c.y + c.spd;
        if (c.up && ny < 32 * ONE)      begin ny = 32 * ONE;  r.up = 1'b0; end
        if (!c.up && ny / ONE > 448)    begin ny = 448 * ONE; r.up = 1'b1; end
        r.x = nx; r.y = ny; r.n = c.n + 1;
        if (ht) begin r.ph = P_PAUSE; r.rh = 1'b1; r.n = 0; end
        else if (r.n == TO) r.ph = P_ESC;
      end
      P_PAUSE: begin
        r.n = c.n + 1;
        if (r.n == HP) begin r.ph = P_FALL; r.n = 0; end
      end
      P_FALL: begin
        ny = c.y + 120;
        if (ny / ONE >= 480) begin ny = 480 * ONE; r.ph = P_DONE; end
        r.y = ny;
      end
      P_ESC: begin
        ny = c.y - 2 * c.spd;
        if (ny < 9 * ONE) begin ny = 8 * ONE; r.ph = P_DONE; end
        r.y = ny;
      end
      default: begin
        r.x = sx * ONE; r.y = 448 * ONE; r.ph = P_IDLE;
      end
    endcase
    return r;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= reset_m(480);
      m1 <= reset_m(950);
      lf <= 16'hACE1;
    end else begin
      m0 <= step_m(m0, start, hit, sl, lf[0], 480);
      m1 <= step_m(m1, start_b, hit_b, sl_b, lf[0], 950);
      lf <= lfsr_step(lf);
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got timeout, expected event (t=%0t)", name, $time);
  endtask

  task automatic cmp_one(input string tag, input mdl_t e, input logic [11:0] x, input logic [11:0] y,
                         input logic v, input logic f, input logic d, input logic r);
    chk({tag, "xpos"}, x, e.x / ONE);
    chk({tag, "ypos"}, y, e.y / ONE);
    chk({tag, "visible"}, v, (e.ph == P_FLY || e.ph == P_PAUSE || e.ph == P_FALL || e.ph == P_ESC));
    chk({tag, "falling"}, f, (e.ph == P_PAUSE || e.ph == P_FALL));
    chk({tag, "dog_enable"}, d, (e.ph == P_DONE));
    chk({tag, "round_hit"}, r, e.rh);
  endtask

  always @(negedge clk) begin
    cmp_one("a_", m0, xpos, ypos, vis, fall, dog, rh);
    cmp_one("b_", m1, xpos_b, ypos_b, vis_b, fall_b, dog_b, rh_b);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt, d0, d1, xbmax, ymax0, dogs;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset, then first flight step
    repeat (5) @(negedge clk);
    chk("t1_idle_x", xpos, 480);
    chk("t1_idle_y", ypos, 448);
    chk("t1_idle_vis", vis, 0);
    chk("t1_idle_dog", dog, 0);
    sl = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t1_vis_after_start", vis, 1);
    @(negedge clk);
    chk("t1_first_up_step", ypos, 447);

    // Hit 50 steps into the flight
    repeat (48) @(negedge clk);
    hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    chk("t3_falling", fall, 1);
    chk("t3_y_at_hit", ypos, 435);
    cnt = 0;
    while (!dog && cnt < 400) begin
      @(negedge clk); cnt++;
      if (cnt == 5) chk("t3_frozen_y", ypos, 435);
    end
    if (!dog) bound_fail("t3_wait_dog");
    chk("t3_cycles_to_dog", cnt, 105);
    chk("t3_ground_y", ypos, 480);
    chk("t3_round_hit", rh, 1);
    @(negedge clk);
    chk("t3_single_pulse", dog, 0);
    chk("t3_respawn_x", xpos, 480);

    // Timeout escape on dut; bounce at right edge on dut_b (needs dx=+)
    sl = 2'd1;
    cnt = 0;
    while (lf[0] !== 1'b1 && cnt < 64) begin @(negedge clk); cnt++; end
    if (lf[0] !== 1'b1) bound_fail("t2_wait_coin");
    start = 1'b1; start_b = 1'b1;
    @(negedge clk); start = 1'b0; start_b = 1'b0;
    d0 = -1; d1 = -1; xbmax = 0; ymax0 = 0;
    for (int c = 1; c <= 900 && (d0 < 0 || d1 < 0); c++) begin
      @(negedge clk);
      if (c == 16) chk("t2_x_reaches_960", xpos_b, 960);
      if (c == 19) chk("t2_x_turns_back", xpos_b, 959);
      if (c == 400) chk("t4_escape_not_fall", {vis, fall}, 2'b10);
      if (int'(xpos_b) > xbmax) xbmax = int'(xpos_b);
      if (int'(ypos) > ymax0) ymax0 = int'(ypos);
      if (dog && d0 < 0) begin
        d0 = c;
        chk("t4_escape_floor", ypos, 8);
        chk("t4_round_miss", rh, 0);
      end
      if (dog_b && d1 < 0) d1 = c;
    end
    if (d0 < 0 || d1 < 0) bound_fail("t4_wait_dog");
    chk("t4_cycles_to_dog", d0, 786);
    chk("t2_cycles_to_dog", d1, 552);
    chk("t2_x_max", xbmax, 960);
    chk("t4_y_no_wrap", ymax0, 447);
    @(negedge clk);
    chk("t4_single_pulse", dog, 0);
    chk("t4_idle_x", xpos, 480);
    chk("t4_idle_y", ypos, 448);
    chk("t4_idle_vis", vis, 0);

    // Hit on the exact timeout cycle; start during FALL is ignored
    sl = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (399) @(negedge clk);
    hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    chk("t5_hit_wins", fall, 1);
    chk("t5_y_at_hit", ypos, 348);
    cnt = 0;
    repeat (12) begin @(negedge clk); cnt++; end
    start = 1'b1;
    repeat (3) begin @(negedge clk); cnt++; end
    start = 1'b0;
    chk("t5_still_falling", fall, 1);
    while (!dog && cnt < 600) begin @(negedge clk); cnt++; end
    if (!dog) bound_fail("t5_wait_dog");
    chk("t5_cycles_to_dog", cnt, 292);
    chk("t5_round_hit", rh, 1);
    repeat (2) @(negedge clk);
    chk("t5_start_ignored", vis, 0);

    // Reset during FALL
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_in_fall", fall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_x", xpos, 480);
    chk("t6_async_y", ypos, 448);
    chk("t6_async_vis", vis, 0);
    chk("t6_async_fall", fall, 0);
    chk("t6_async_rh", rh, 0);
    dogs = 0;
    repeat (4) begin @(negedge clk); dogs += int'(dog); end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); dogs += int'(dog); end
    chk("t6_no_dog_pulse", dogs, 0);
    chk("t6_idle_after", vis, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
